// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-channel external interrupt controller.
// The controller synchronises each input and detects edges or levels per channel.
// It selects the lowest eligible index as the winner.
// A claim/complete handshake with the trap handler prevents nested interrupts.
module irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               csr_meie,
  input  logic               claim,
  input  logic               complete,
  output logic [NUM_IRQ-1:0] pending,
  output logic               g_interrupt,
  output logic               g_interrupt_1shot,
  output logic [ID_W-1:0]    claim_id,
  output logic               claim_valid,
  output logic               in_service
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                                state_reg;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   sync_reg;
  logic [NUM_IRQ-1:0]                    s_d_reg;
  logic [NUM_IRQ-1:0]                    pending_reg;
  logic [NUM_IRQ-1:0]                    pending_next;
  logic                                  g_interrupt_reg;
  logic                                  g_interrupt_dly_reg;
  logic [ID_W-1:0]                       claim_id_reg;
  logic                                  claim_valid_reg;
  logic                                  in_service_reg;

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [ID_W-1:0]    win;
  logic               any_eligible;
  logic               take;

  assign s            = sync_reg[SYNC_STAGES-1];
  assign rise         = s & ~s_d_reg;
  assign eligible     = pending_reg & irq_enable;
  assign any_eligible = |eligible;
  // Two's-complement trick isolates the lowest set bit of eligible.
  assign win_onehot   = eligible & (~eligible + 1'b1);
  // A claim succeeds only when the core has seen a request and one is still eligible.
  assign take         = (state_reg == IDLE) && claim && g_interrupt_reg && any_eligible;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win = ID_W'(i);
    end
  end

  // Next-state logic for each channel's pending bit.
  // A fresh edge wins over a coincident claim, so the new event is not lost.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      assign pending_next[gi] = irq_edge_mode[gi]
                              ? ((pending_reg[gi] & ~(take & win_onehot[gi])) | rise[gi])
                              : s[gi];
    end
  endgenerate

  // Synchroniser chain, edge-detect delay and pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= '0;
      s_d_reg     <= '0;
      pending_reg <= '0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], irq_in};
      s_d_reg     <= s;
      pending_reg <= pending_next;
    end
  end

  // Claim/complete FSM with registered request and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      g_interrupt_reg     <= 1'b0;
      g_interrupt_dly_reg <= 1'b0;
      claim_id_reg        <= '0;
      claim_valid_reg     <= 1'b0;
      in_service_reg      <= 1'b0;
    end else begin
      g_interrupt_dly_reg <= g_interrupt_reg;
      claim_valid_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (take) begin
            claim_id_reg    <= win;
            claim_valid_reg <= 1'b1;
            in_service_reg  <= 1'b1;
            g_interrupt_reg <= 1'b0;
            state_reg       <= ACTIVE;
          end else begin
            g_interrupt_reg <= csr_meie & any_eligible;
          end
        end
        ACTIVE: begin
          g_interrupt_reg <= 1'b0;
          if (complete) begin
            in_service_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pending           = pending_reg;
  assign g_interrupt       = g_interrupt_reg;
  assign g_interrupt_1shot = g_interrupt_reg & ~g_interrupt_dly_reg;
  assign claim_id          = claim_id_reg;
  assign claim_valid       = claim_valid_reg;
  assign in_service        = in_service_reg;

endmodule
